// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display scan-out, clear engine and pixel writer
// share one RAM port under fixed priority display > clear > writer.
module vga_fb_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              in_blank,
  input  logic              vblank_only,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // The last framebuffer location; the clear engine stops after writing it.
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_clrCnt;
  logic [ADDR_W-1:0] w_clrCntNext;
  logic [DATA_W-1:0] r_clrColor;
  logic [DATA_W-1:0] w_clrColorNext;
  logic              w_doneNext;
  logic              w_clrGnt;
  logic              w_wrGnt;
  logic [1:0]        r_rdPipe;

  // The clear engine only gets the port in cycles the display leaves free.
  assign w_clrGnt   = (r_state == CLEAR) & ~disp_req;
  assign wr_ready   = (r_state == IDLE) & ~disp_req & (~vblank_only | in_blank);
  assign w_wrGnt    = wr_valid & wr_ready;
  assign clear_busy = (r_state == CLEAR);

  // Next-state logic: start a fill from IDLE, step the counter on each granted clear write.
  always_comb begin
    w_stateNext    = r_state;
    w_clrCntNext   = r_clrCnt;
    w_clrColorNext = r_clrColor;
    w_doneNext     = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear_start) begin
          w_stateNext    = CLEAR;
          w_clrCntNext   = '0;
          w_clrColorNext = clear_color;
        end
      end
      CLEAR: begin
        if (w_clrGnt) begin
          if (r_clrCnt == LAST_ADDR) begin
            w_stateNext = IDLE;
            w_doneNext  = 1'b1;
          end else begin
            w_clrCntNext = r_clrCnt + 1'b1;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State, clear counter, latched color and the done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_clrCnt   <= '0;
      r_clrColor <= '0;
      clear_done <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_clrCnt   <= w_clrCntNext;
      r_clrColor <= w_clrColorNext;
      clear_done <= w_doneNext;
    end
  end

  // Registered RAM port: the winner of this cycle drives the RAM next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (disp_req) begin
      mem_addr <= disp_addr;
      mem_we   <= 1'b0;
    end else if (w_clrGnt) begin
      mem_addr  <= r_clrCnt;
      mem_we    <= 1'b1;
      mem_wdata <= r_clrColor;
    end else if (w_wrGnt) begin
      mem_addr  <= wr_addr;
      mem_we    <= 1'b1;
      mem_wdata <= wr_data;
    end else begin
      mem_we <= 1'b0;
    end
  end

  // Display read return: address register plus RAM latency, then capture the pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdPipe    <= '0;
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
    end else begin
      r_rdPipe    <= {r_rdPipe[0], disp_req};
      disp_rvalid <= r_rdPipe[1];
      if (r_rdPipe[1]) begin
        disp_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter (ADDR_W=4): directed scenarios followed by
// random traffic, all compared against a behavioural framebuffer model.
module tb_vga_fb_arbiter;
  localparam int AW = 4;
  localparam int DW = 24;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          resetn;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          in_blank;
  logic          vblank_only;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          clear_start;
  logic [DW-1:0] clear_color;
  logic          clear_busy;
  logic          clear_done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [0:DEPTH-1];

  int errors = 0;
  int checks = 0;

  // Reference model: framebuffer image, clear progress and expected port values.
  logic          mClearing;
  int            mIdx;
  logic [DW-1:0] mColor;
  logic [DW-1:0] image [0:DEPTH-1];
  logic          pendWe;
  logic [AW-1:0] pendAddr;
  logic [DW-1:0] pendData;
  logic          expWe;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expWdata;
  logic          expRvalid;
  logic [DW-1:0] expRdata;
  logic          expDone;
  logic          histV [0:2];
  logic [DW-1:0] histD [0:2];

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .in_blank(in_blank), .vblank_only(vblank_only),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous single-port RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic modelReady();
    return !mClearing && !disp_req && (!vblank_only || in_blank);
  endfunction

  task automatic modelReset();
    mClearing = 1'b0;
    mIdx      = 0;
    mColor    = '0;
    pendWe    = 1'b0;
    expWe     = 1'b0;
    expAddr   = '0;
    expWdata  = '0;
    expRvalid = 1'b0;
    expRdata  = '0;
    expDone   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      histV[i] = 1'b0;
      histD[i] = '0;
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic modelEdge();
    logic          startNow;
    logic          readyNow;
    logic          rdV;
    logic [DW-1:0] rdD;
    if (pendWe) image[pendAddr] = pendData;
    pendWe   = 1'b0;
    startNow = !mClearing && clear_start;
    readyNow = modelReady();
    expDone  = 1'b0;
    rdV      = disp_req;
    rdD      = disp_req ? image[disp_addr] : '0;
    if (disp_req) begin
      expWe   = 1'b0;
      expAddr = disp_addr;
    end else if (mClearing) begin
      expWe    = 1'b1;
      expAddr  = AW'(mIdx);
      expWdata = mColor;
      mIdx++;
      if (mIdx == DEPTH) begin
        mClearing = 1'b0;
        expDone   = 1'b1;
      end
    end else if (wr_valid && readyNow) begin
      expWe    = 1'b1;
      expAddr  = wr_addr;
      expWdata = wr_data;
    end else begin
      expWe = 1'b0;
    end
    if (expWe) begin
      pendWe   = 1'b1;
      pendAddr = expAddr;
      pendData = expWdata;
    end
    if (startNow) begin
      mClearing = 1'b1;
      mIdx      = 0;
      mColor    = clear_color;
    end
    histV[2] = histV[1]; histD[2] = histD[1];
    histV[1] = histV[0]; histD[1] = histD[0];
    histV[0] = rdV;      histD[0] = rdD;
    expRvalid = histV[2];
    if (histV[2]) expRdata = histD[2];
  endtask

  task automatic applyStimulus(input logic dr, input logic [AW-1:0] da, input logic wv,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic ib, input logic vo, input logic cs,
                               input logic [DW-1:0] cc);
    disp_req = dr; disp_addr = da;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    in_blank = ib; vblank_only = vo;
    clear_start = cs; clear_color = cc;
    #1;
    chk("wr_ready", {31'b0, wr_ready}, {31'b0, modelReady()});
  endtask

  task automatic checkOutput();
    chk("mem_we",      {31'b0, mem_we},      {31'b0, expWe});
    chk("mem_addr",    {28'b0, mem_addr},    {28'b0, expAddr});
    chk("mem_wdata",   {8'b0, mem_wdata},    {8'b0, expWdata});
    chk("disp_rvalid", {31'b0, disp_rvalid}, {31'b0, expRvalid});
    chk("disp_rdata",  {8'b0, disp_rdata},   {8'b0, expRdata});
    chk("clear_busy",  {31'b0, clear_busy},  {31'b0, mClearing});
    chk("clear_done",  {31'b0, clear_done},  {31'b0, expDone});
  endtask

  task automatic checkReset();
    chk("rst_mem_we",      {31'b0, mem_we},      32'd0);
    chk("rst_mem_addr",    {28'b0, mem_addr},    32'd0);
    chk("rst_mem_wdata",   {8'b0, mem_wdata},    32'd0);
    chk("rst_disp_rvalid", {31'b0, disp_rvalid}, 32'd0);
    chk("rst_disp_rdata",  {8'b0, disp_rdata},   32'd0);
    chk("rst_clear_busy",  {31'b0, clear_busy},  32'd0);
    chk("rst_clear_done",  {31'b0, clear_done},  32'd0);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int busyCnt;
    int doneCnt;
    int wrCnt;
    int stalls;
    resetn = 1'b0;
    disp_req = 1'b0; disp_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    in_blank = 1'b0; vblank_only = 1'b0; clear_start = 1'b0; clear_color = '0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset();
    resetn = 1'b1;

    $display("[TB] plain clear with color 00FF00");
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 24'h00FF00);
    stepCycle();
    busyCnt = clear_busy ? 1 : 0; doneCnt = 0; wrCnt = 0;
    for (int i = 0; i < 40 && mClearing; i++) begin
      idle();
      stepCycle();
      if (clear_busy) busyCnt++;
      if (clear_done) doneCnt++;
      if (mem_we) begin
        chk("clr_seq_addr", {28'b0, mem_addr}, wrCnt);
        wrCnt++;
      end
    end
    idle();
    stepCycle();
    if (clear_done) doneCnt++;
    chk("clr_busy_cycles", busyCnt, 16);
    chk("clr_done_count", doneCnt, 1);
    chk("clr_write_count", wrCnt, 16);

    $display("[TB] write then display read of address 5");
    applyStimulus(1'b0, '0, 1'b1, 4'h5, 24'hABCDEF, 1'b0, 1'b0, 1'b0, '0);
    stepCycle();
    applyStimulus(1'b1, 4'h5, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    stepCycle();
    idle();
    stepCycle();
    chk("rd_not_early", {31'b0, disp_rvalid}, 32'd0);
    idle();
    stepCycle();
    chk("rd_valid", {31'b0, disp_rvalid}, 32'd1);
    chk("rd_data", {8'b0, disp_rdata}, 32'hABCDEF);

    $display("[TB] vblank_only gating");
    applyStimulus(1'b0, '0, 1'b1, 4'h3, 24'h112233, 1'b0, 1'b1, 1'b0, '0);
    chk("vb_ready_low", {31'b0, wr_ready}, 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 4'h3, 24'h112233, 1'b1, 1'b1, 1'b0, '0);
    chk("vb_ready_high", {31'b0, wr_ready}, 32'd1);
    stepCycle();

    $display("[TB] writer blocked by display for 3 cycles");
    wrCnt = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, AW'(i), 1'b1, 4'h9, 24'h123456, 1'b0, 1'b0, 1'b0, '0);
      chk("disp_block_ready", {31'b0, wr_ready}, 32'd0);
      stepCycle();
      if (mem_we) wrCnt++;
    end
    applyStimulus(1'b0, '0, 1'b1, 4'h9, 24'h123456, 1'b0, 1'b0, 1'b0, '0);
    chk("disp_release_ready", {31'b0, wr_ready}, 32'd1);
    stepCycle();
    if (mem_we && mem_addr == 4'h9) wrCnt++;
    idle();
    stepCycle();
    if (mem_we) wrCnt++;
    chk("disp_block_writes", wrCnt, 1);

    $display("[TB] clear with interleaved display requests");
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 24'h0000AA);
    stepCycle();
    busyCnt = clear_busy ? 1 : 0; wrCnt = 0; stalls = 0;
    for (int i = 0; i < 60 && mClearing; i++) begin
      applyStimulus((i % 3) == 1, AW'($urandom_range(0, DEPTH - 1)), 1'b1, 4'h2, 24'h777777,
                    1'b1, 1'b0, 1'b1, 24'hFFFFFF);
      if (disp_req) stalls++;
      stepCycle();
      if (clear_busy) busyCnt++;
      if (mem_we) wrCnt++;
    end
    chk("clr_stall_busy", busyCnt, 16 + stalls);
    chk("clr_stall_writes", wrCnt, 16);

    $display("[TB] reset in the middle of a clear");
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 24'h5A5A5A);
    stepCycle();
    for (int i = 0; i < 20 && !(expWe && expAddr == 4'h7); i++) begin
      idle();
      stepCycle();
    end
    chk("mid_clear_addr", {28'b0, mem_addr}, 32'd7);
    #2 resetn = 1'b0;
    #1;
    modelReset();
    checkReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset();
    resetn = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 4'hC, 24'hC0FFEE, 1'b0, 1'b0, 1'b0, '0);
    chk("post_reset_ready", {31'b0, wr_ready}, 32'd1);
    stepCycle();

    $display("[TB] full clear then random traffic");
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 24'h102030);
    stepCycle();
    for (int i = 0; i < 40 && mClearing; i++) begin
      idle();
      stepCycle();
    end
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 30, AW'($urandom_range(0, DEPTH - 1)),
                    $urandom_range(0, 99) < 60, AW'($urandom_range(0, DEPTH - 1)),
                    DW'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 3, DW'($urandom));
      stepCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
